pattern_player: RTL
===================

Name: pattern_player

Overview:
- Downstream consumer of the pattern shift register and the round counter. Replays the stored pattern on the 8 one-hot LEDs before the player's input phase.
- Each 3-bit entry lights one LED for ON_CYCLES cycles, followed by an all-dark gap of OFF_CYCLES cycles.
- Issues a one-cycle done strobe when playback ends, so the mode FSM can enable the input handler.
- Supports oldest-first (classic/time modes) and newest-first (reverse mode) playback order.

Parameters:
MAX_LEN, 25, maximum number of entries held in the pattern vector (pattern width = 3*MAX_LEN).
ON_CYCLES, 50000000, cycles each LED is lit; must be >= 1.
OFF_CYCLES, 12500000, dark cycles after each entry; must be >= 1.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin playback; sampled only in IDLE.
abort  input  1  cancel playback immediately (play_again / mode change).
newest_first  input  1  1 = play entry 0 first; 0 = play entry length-1 first.
pattern  input  3*MAX_LEN  packed entries; entry k occupies bits [3k+2:3k]; entry 0 is the newest.
length  input  16  number of valid entries.
led  output  8  one-hot LED drive; all zero when dark.
busy  output  1  high while in ON or GAP.
done  output  1  one-cycle pulse when playback completes normally.
step_idx  output  5  0-based position in playback order of the entry currently shown.

Behaviour:
- Reset values, applied asynchronously while rst is high: state=IDLE, led=0, busy=0, done=0, step_idx=0. All internal counters and latches are cleared.
- States:
  - IDLE: led=0, busy=0.
  - ON: led=onehot(current entry), busy=1.
  - GAP: led=0, busy=1.
- Start (IDLE, start=1, abort=0):
  - Latch pattern, newest_first and eff_len = min(length, MAX_LEN).
  - If eff_len=0: remain in IDLE and pulse done the next cycle.
  - Otherwise: go to ON next cycle with step_idx=0. led is valid in the cycle after start (latency 1).
- Entry selection: for playback position p, the entry index is p when newest_first=1, else eff_len-1-p. led = 8'b1 << entry_value.
- ON lasts exactly ON_CYCLES cycles, then GAP.
- GAP lasts exactly OFF_CYCLES cycles. Then:
  - if step_idx < eff_len-1: increment step_idx and return to ON;
  - else: go to IDLE, with done=1 for exactly one cycle in the first IDLE cycle. busy is already 0 in that cycle.
- Total busy cycles = eff_len*(ON_CYCLES+OFF_CYCLES).
- Latched operands: pattern and length are latched at start. Changes during playback are ignored, so the shift register may be updated concurrently.
- start while busy: ignored.
- abort in any state: next cycle state=IDLE, led=0, busy=0, step_idx=0, no done pulse.
- abort and start in the same cycle: abort wins and playback does not begin.
- start in the same cycle as done: accepted, because the block is in IDLE.
- Dwell counter width is clog2(max(ON_CYCLES,OFF_CYCLES)) bits. It reloads on every state transition and never wraps.
- Out-of-range length: length > MAX_LEN is clamped to MAX_LEN; no error is flagged.
- led is registered (glitch-free) and is never multi-hot.

Test Plan:
- Basic playback (ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=25): pattern entries {e2=5, e1=0, e0=7}, length=3, newest_first=0, start pulse at cycle 0.
  - led sequence: 0x20 for cycles 1-4, 0 for 5-6, 0x01 for 7-10, 0 for 11-12, 0x80 for 13-16, 0 for 17-18.
  - done=1 at cycle 19 only; busy high for cycles 1-18.
- Reverse order: same stimulus with newest_first=1 -> led order 0x80, 0x01, 0x20; step_idx 0,1,2 in step with the entries.
- Zero length: length=0, start -> led stays 0, busy never rises, done=1 in cycle 1.
- Abort mid-entry: abort at cycle 8 of the basic case -> led=0 and busy=0 from cycle 9; done never asserts; a new start at cycle 12 restarts from step_idx=0.
- Clamping and ignored start: length=40 -> exactly 25 ON phases then done; a start pulse during playback neither extends nor restarts it.
- Asynchronous reset: rst asserted between clock edges during ON -> led=0 and busy=0 immediately, without waiting for a clock edge; after release the block idles until the next start.

Source files
------------

// File: rtl/pattern_player_if.sv
// Handshake and data bundle between the mode FSM / pattern store and the pattern player.
// The master side issues start/abort and supplies the pattern; the slave side drives the LEDs and status.
interface pattern_player_if #(
  parameter int MAX_LEN = 25
);
  logic                   start;
  logic                   abort;
  logic                   newest_first;
  logic [3*MAX_LEN-1:0]   pattern;
  logic [15:0]            length;
  logic [7:0]             led;
  logic                   busy;
  logic                   done;
  logic [4:0]             step_idx;

  modport master (
    output start, abort, newest_first, pattern, length,
    input  led, busy, done, step_idx
  );

  modport slave (
    input  start, abort, newest_first, pattern, length,
    output led, busy, done, step_idx
  );
endinterface

// File: rtl/pattern_player.sv
// Replays a latched pattern on eight one-hot LEDs: ON_CYCLES lit, OFF_CYCLES dark per entry.
// Latency 1 from start to first LED; done pulses in the first idle cycle; start ignored while busy.
module pattern_player #(
  parameter int MAX_LEN    = 25,
  parameter int ON_CYCLES  = 50000000,
  parameter int OFF_CYCLES = 12500000
) (
  input  logic              clk,
  input  logic              rst,
  pattern_player_if.slave   bus
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [4:0]             r_step;
  logic [15:0]            r_len;
  logic                   r_nf;
  logic [3*MAX_LEN-1:0]   r_pattern;
  logic [7:0]             r_led;
  logic                   r_busy;
  logic                   r_done;

  logic [15:0]            w_eff_len;
  logic [7:0]             w_first_led;
  logic [7:0]             w_next_led;
  logic                   w_last;

  // Map a playback position to its entry and return the matching one-hot LED word.
  function automatic logic [7:0] onehot_at(
    input logic [3*MAX_LEN-1:0] pat,
    input logic                 nf,
    input logic [15:0]          len,
    input logic [4:0]           pos
  );
    logic [15:0] idx;
    logic [2:0]  val;
    idx = nf ? {11'd0, pos} : (len - 16'd1 - {11'd0, pos});
    val = 3'd0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (idx == 16'(k)) val = pat[3*k +: 3];
    end
    return 8'd1 << val;
  endfunction

  assign w_eff_len   = (bus.length > 16'(MAX_LEN)) ? 16'(MAX_LEN) : bus.length;
  assign w_first_led = onehot_at(bus.pattern, bus.newest_first, w_eff_len, 5'd0);
  assign w_next_led  = onehot_at(r_pattern, r_nf, r_len, r_step + 5'd1);
  assign w_last      = ({11'd0, r_step} >= (r_len - 16'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_step    <= '0;
      r_len     <= '0;
      r_nf      <= 1'b0;
      r_pattern <= '0;
      r_led     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_step  <= '0;
        r_led   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_pattern <= bus.pattern;
              r_nf      <= bus.newest_first;
              r_len     <= w_eff_len;
              r_step    <= '0;
              if (w_eff_len == 16'd0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_ON;
                r_cnt   <= CW'(ON_CYCLES - 1);
                r_led   <= w_first_led;
                r_busy  <= 1'b1;
              end
            end
          end
          S_ON: begin
            if (r_cnt == '0) begin
              r_state <= S_GAP;
              r_cnt   <= CW'(OFF_CYCLES - 1);
              r_led   <= '0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_GAP: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else if (!w_last) begin
              r_state <= S_ON;
              r_cnt   <= CW'(ON_CYCLES - 1);
              r_step  <= r_step + 5'd1;
              r_led   <= w_next_led;
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_step  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.led      = r_led;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.step_idx = r_step;

endmodule
